// File: rtl/rprelu_tdm.sv
// rprelu_tdm: time-multiplexed RPReLU activation stage.
// CHANNEL_NUM channels are streamed as CHANNEL_NUM/LANES beats of LANES lanes.
// Per-channel beta/gamma/zeta live in an internal bank written via the cfg port.
// Two-stage valid/ready pipeline: stage 1 subtract/compare, stage 2 multiply/saturate.
module rprelu_tdm #(
    parameter int DATA_WIDTH  = 16,
    parameter int PARA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int LANES       = 8,
    parameter int SHIFT       = 8
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 cfg_we,
    input  logic [1:0]                           cfg_sel,
    input  logic [$clog2(CHANNEL_NUM)-1:0]       cfg_addr,
    input  logic [PARA_WIDTH-1:0]                cfg_wdata,
    input  logic                                 bypass,
    input  logic                                 grp_clr,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]          in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LANES*DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(CHANNEL_NUM/LANES)-1:0] out_grp,
    output logic                                 out_last,
    output logic                                 out_sat
);
    localparam int DW  = DATA_WIDTH;
    localparam int PW  = PARA_WIDTH;
    localparam int G   = CHANNEL_NUM / LANES;
    localparam int AW  = $clog2(CHANNEL_NUM);
    localparam int GW  = $clog2(G);
    localparam int PRW = DW + 1 + PW;
    localparam int RW  = PRW + 1;

    typedef logic signed [PW-1:0] para_t;
    typedef logic signed [DW-1:0] data_t;
    typedef logic signed [DW:0]   diff_t;

    para_t beta_q  [CHANNEL_NUM];
    para_t beta_d  [CHANNEL_NUM];
    para_t gamma_q [CHANNEL_NUM];
    para_t gamma_d [CHANNEL_NUM];
    para_t zeta_q  [CHANNEL_NUM];
    para_t zeta_d  [CHANNEL_NUM];

    logic [GW-1:0] grp_q, grp_d;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_bypass_q, s1_bypass_d;
    logic [GW-1:0] s1_grp_q, s1_grp_d;
    data_t         s1_d_q    [LANES];
    data_t         s1_d_d    [LANES];
    diff_t         s1_dg_q   [LANES];
    diff_t         s1_dg_d   [LANES];
    logic          s1_pos_q  [LANES];
    logic          s1_pos_d  [LANES];
    para_t         s1_beta_q [LANES];
    para_t         s1_beta_d [LANES];
    para_t         s1_zeta_q [LANES];
    para_t         s1_zeta_d [LANES];

    logic                   s2_valid_q, s2_valid_d;
    logic [LANES*DW-1:0]    out_data_q, out_data_d;
    logic [GW-1:0]          out_grp_q, out_grp_d;
    logic                   out_last_q, out_last_d;
    logic                   out_sat_q, out_sat_d;

    logic s1_ready, s2_ready, accept;

    assign s2_ready  = !s2_valid_q || out_ready;
    assign s1_ready  = !s1_valid_q || s2_ready;
    assign in_ready  = s1_ready;
    assign accept    = in_valid && s1_ready;

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_grp   = out_grp_q;
    assign out_last  = out_last_q;
    assign out_sat   = out_sat_q;

    // Parameter bank update: reserved select and out-of-range addresses are dropped.
    always_comb begin
        beta_d  = beta_q;
        gamma_d = gamma_q;
        zeta_d  = zeta_q;
        if (cfg_we && (int'(cfg_addr) < CHANNEL_NUM)) begin
            case (cfg_sel)
                2'd0:    beta_d[cfg_addr]  = cfg_wdata;
                2'd1:    gamma_d[cfg_addr] = cfg_wdata;
                2'd2:    zeta_d[cfg_addr]  = cfg_wdata;
                default: ;
            endcase
        end
    end

    // Group counter: clear wins over the accept increment.
    always_comb begin
        grp_d = grp_q;
        if (grp_clr) begin
            grp_d = '0;
        end else if (accept) begin
            grp_d = (grp_q == GW'(G - 1)) ? '0 : grp_q + 1'b1;
        end
    end

    // Stage 1: per-lane d - gamma and d > gamma, and latch the channel's beta/zeta.
    always_comb begin
        logic [AW-1:0] ch;
        data_t         d;
        data_t         g;
        ch          = '0;
        d           = '0;
        g           = '0;
        s1_valid_d  = s1_valid_q;
        s1_bypass_d = s1_bypass_q;
        s1_grp_d    = s1_grp_q;
        s1_d_d      = s1_d_q;
        s1_dg_d     = s1_dg_q;
        s1_pos_d    = s1_pos_q;
        s1_beta_d   = s1_beta_q;
        s1_zeta_d   = s1_zeta_q;
        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_bypass_d = bypass;
                s1_grp_d    = grp_q;
                for (int unsigned l = 0; l < LANES; l++) begin
                    ch           = AW'(grp_q * LANES + l);
                    d            = in_data[l*DW +: DW];
                    g            = DW'(gamma_q[ch]);
                    s1_d_d[l]    = d;
                    s1_dg_d[l]   = diff_t'(d) - diff_t'(g);
                    s1_pos_d[l]  = (d > g);
                    s1_beta_d[l] = beta_q[ch];
                    s1_zeta_d[l] = zeta_q[ch];
                end
            end
        end
    end

    // Stage 2: scale the negative branch, add zeta, saturate; bypass passes d through.
    always_comb begin
        logic signed [PRW-1:0] prod;
        logic signed [PRW-1:0] neg;
        logic signed [RW-1:0]  r;
        logic                  fits;
        prod       = '0;
        neg        = '0;
        r          = '0;
        fits       = 1'b0;
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_grp_d  = out_grp_q;
        out_last_d = out_last_q;
        out_sat_d  = out_sat_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_grp_d  = s1_grp_q;
                out_last_d = (s1_grp_q == GW'(G - 1));
                out_sat_d  = 1'b0;
                for (int unsigned l = 0; l < LANES; l++) begin
                    prod = PRW'(s1_beta_q[l]) * PRW'(s1_dg_q[l]);
                    neg  = prod >>> SHIFT;
                    r    = s1_pos_q[l] ? RW'(s1_dg_q[l]) + RW'(s1_zeta_q[l])
                                       : RW'(neg) + RW'(s1_zeta_q[l]);
                    fits = (&r[RW-1:DW-1]) || !(|r[RW-1:DW-1]);
                    if (s1_bypass_q) begin
                        out_data_d[l*DW +: DW] = s1_d_q[l];
                    end else if (fits) begin
                        out_data_d[l*DW +: DW] = r[DW-1:0];
                    end else begin
                        out_data_d[l*DW +: DW] = r[RW-1] ? {1'b1, {(DW-1){1'b0}}}
                                                         : {1'b0, {(DW-1){1'b1}}};
                        out_sat_d = 1'b1;
                    end
                end
            end
        end
    end

    // State registers; reset empties the pipeline and clears the parameter bank.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
                beta_q[c]  <= '0;
                gamma_q[c] <= '0;
                zeta_q[c]  <= '0;
            end
            for (int unsigned l = 0; l < LANES; l++) begin
                s1_d_q[l]    <= '0;
                s1_dg_q[l]   <= '0;
                s1_pos_q[l]  <= 1'b0;
                s1_beta_q[l] <= '0;
                s1_zeta_q[l] <= '0;
            end
            grp_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_grp_q    <= '0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_grp_q   <= '0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            beta_q      <= beta_d;
            gamma_q     <= gamma_d;
            zeta_q      <= zeta_d;
            grp_q       <= grp_d;
            s1_valid_q  <= s1_valid_d;
            s1_bypass_q <= s1_bypass_d;
            s1_grp_q    <= s1_grp_d;
            s1_d_q      <= s1_d_d;
            s1_dg_q     <= s1_dg_d;
            s1_pos_q    <= s1_pos_d;
            s1_beta_q   <= s1_beta_d;
            s1_zeta_q   <= s1_zeta_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            out_grp_q   <= out_grp_d;
            out_last_q  <= out_last_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_rprelu_tdm.sv
// Directed testbench for rprelu_tdm with default parameters.
`timescale 1ns/1ps
module tb_rprelu_tdm;
    localparam int DW = 16;
    localparam int LANES = 8;
    localparam int G = 16;

    logic           clk = 1'b0;
    logic           rstn;
    logic           cfg_we;
    logic [1:0]     cfg_sel;
    logic [6:0]     cfg_addr;
    logic [15:0]    cfg_wdata;
    logic           bypass;
    logic           grp_clr;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic [3:0]     out_grp;
    logic           out_last;
    logic           out_sat;

    int checks = 0;
    int errors = 0;

    logic [127:0] q_data[$];
    logic [3:0]   q_grp[$];
    logic         q_last[$];
    logic         q_sat[$];
    int           stall_bad;
    int           rdy_bad;

    rprelu_tdm #(.DATA_WIDTH(16), .PARA_WIDTH(16), .CHANNEL_NUM(128), .LANES(8), .SHIFT(8)) dut (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .bypass(bypass), .grp_clr(grp_clr), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_grp(out_grp), .out_last(out_last), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] exp_vec(input int i, input int g);
        logic [127:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++) v[l*DW +: DW] = 16'(i + g*8 + l);
        return v;
    endfunction

    task automatic do_reset;
        rstn = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; grp_clr = 1'b0; bypass = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [6:0] addr, input logic [15:0] val);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = val;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // One isolated beat on lane 0 at grp 0; cfg_when 1 = write in the cycle before accept, 2 = same cycle.
    task automatic run_beat(input logic signed [15:0] d0, input logic byp, input int cfg_when,
                            input logic [1:0] sel, input logic [15:0] val,
                            output logic signed [15:0] o0, output logic sat, output int lat);
        out_ready = 1'b1;
        grp_clr = 1'b1;
        if (cfg_when == 1) begin cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 7'd0; cfg_wdata = val; end
        @(posedge clk); #1;
        grp_clr = 1'b0; cfg_we = 1'b0;
        if (cfg_when == 2) begin cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 7'd0; cfg_wdata = val; end
        in_valid = 1'b1; in_data = '0; in_data[15:0] = d0; bypass = byp;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0; bypass = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        o0 = out_data[15:0];
        sat = out_sat;
    endtask

    // Streams n beats (lane value = beat index), recording outputs and handshake violations.
    task automatic stream(input int n, input int clr_at, input bit rnd);
        int sent, got, inflight, cyc;
        logic exp_rdy, acc, dlv, prev_stall;
        logic [127:0] pdata;
        logic [3:0] pgrp;
        logic plast, psat;
        q_data.delete(); q_grp.delete(); q_last.delete(); q_sat.delete();
        stall_bad = 0; rdy_bad = 0;
        grp_clr = 1'b1; out_ready = 1'b1; in_valid = 1'b0; bypass = 1'b0; cfg_we = 1'b0;
        @(posedge clk); #1;
        sent = 0; got = 0; inflight = 0; cyc = 0; prev_stall = 1'b0;
        pdata = '0; pgrp = '0; plast = 1'b0; psat = 1'b0;
        while (got < n && cyc < 2000) begin
            out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_valid = (sent < n);
            for (int l = 0; l < LANES; l++) in_data[l*DW +: DW] = 16'(sent);
            grp_clr = (sent == clr_at);
            #1;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== pdata || out_grp !== pgrp ||
                               out_last !== plast || out_sat !== psat)) stall_bad++;
            exp_rdy = !(inflight == 2 && !out_ready);
            if (in_ready !== exp_rdy) rdy_bad++;
            dlv = out_valid && out_ready;
            acc = in_valid && in_ready;
            if (dlv) begin
                q_data.push_back(out_data); q_grp.push_back(out_grp);
                q_last.push_back(out_last); q_sat.push_back(out_sat);
                got++;
            end
            prev_stall = out_valid && !out_ready;
            pdata = out_data; pgrp = out_grp; plast = out_last; psat = out_sat;
            if (acc) sent++;
            inflight = inflight + int'(acc) - int'(dlv);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; grp_clr = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
        bypass = 1'b0; grp_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (out_grp !== 4'd0) begin errors++; $display("FAIL reset_out_grp: got %0d expected 0", out_grp); end
        checks++; if (out_last !== 1'b0 || out_sat !== 1'b0) begin errors++; $display("FAIL reset_last_sat: got %b%b expected 00", out_last, out_sat); end
    endtask

    task automatic test_positive;
        logic signed [15:0] o; logic s; int lat;
        cfg_write(2'd0, 7'd0, 16'd64);
        cfg_write(2'd1, 7'd0, 16'd10);
        cfg_write(2'd2, 7'd0, 16'd5);
        run_beat(16'sd20, 1'b0, 0, 2'd0, 16'd0, o, s, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL pos_latency: got %0d expected 2", lat); end
        checks++; if (o !== 16'sd15) begin errors++; $display("FAIL pos_d20: got %0d expected 15", o); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL pos_sat: got %b expected 0", s); end
    endtask

    task automatic test_negative;
        logic signed [15:0] o; logic s; int lat;
        run_beat(16'sd2, 1'b0, 0, 2'd0, 16'd0, o, s, lat);
        checks++; if (o !== 16'sd3 || s !== 1'b0) begin errors++; $display("FAIL neg_d2: got %0d sat %b expected 3 sat 0", o, s); end
        run_beat(16'sd10, 1'b0, 0, 2'd0, 16'd0, o, s, lat);
        checks++; if (o !== 16'sd5) begin errors++; $display("FAIL neg_equal: got %0d expected 5", o); end
        run_beat(-16'sd246, 1'b0, 0, 2'd0, 16'd0, o, s, lat);
        checks++; if (o !== -16'sd59 || s !== 1'b0) begin errors++; $display("FAIL neg_d-246: got %0d sat %b expected -59 sat 0", o, s); end
    endtask

    task automatic test_saturation;
        logic signed [15:0] o; logic s; int lat;
        cfg_write(2'd1, 7'd0, 16'h8000);
        cfg_write(2'd2, 7'd0, 16'h7fff);
        run_beat(16'sh7fff, 1'b0, 0, 2'd0, 16'd0, o, s, lat);
        checks++; if (o !== 16'sh7fff) begin errors++; $display("FAIL sat_pos_value: got %0d expected 32767", o); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL sat_pos_flag: got %b expected 1", s); end
        cfg_write(2'd0, 7'd0, 16'h7fff);
        cfg_write(2'd1, 7'd0, 16'h7fff);
        cfg_write(2'd2, 7'd0, 16'h0000);
        run_beat(16'sh8000, 1'b0, 0, 2'd0, 16'd0, o, s, lat);
        checks++; if (o !== 16'sh8000) begin errors++; $display("FAIL sat_neg_value: got %0d expected -32768", o); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL sat_neg_flag: got %b expected 1", s); end
    endtask

    task automatic test_config_bypass;
        logic signed [15:0] o; logic s; int lat;
        cfg_write(2'd0, 7'd0, 16'd64);
        cfg_write(2'd1, 7'd0, 16'd10);
        cfg_write(2'd2, 7'd0, 16'd5);
        run_beat(16'sd20, 1'b0, 1, 2'd1, 16'd0, o, s, lat);
        checks++; if (o !== 16'sd25) begin errors++; $display("FAIL cfg_before_accept: got %0d expected 25", o); end
        run_beat(16'sd20, 1'b0, 2, 2'd1, 16'd30, o, s, lat);
        checks++; if (o !== 16'sd25) begin errors++; $display("FAIL cfg_same_cycle: got %0d expected 25", o); end
        run_beat(16'sd20, 1'b0, 0, 2'd0, 16'd0, o, s, lat);
        checks++; if (o !== 16'sd2) begin errors++; $display("FAIL cfg_new_gamma: got %0d expected 2", o); end
        run_beat(16'sd20, 1'b0, 1, 2'd3, 16'd0, o, s, lat);
        checks++; if (o !== 16'sd2) begin errors++; $display("FAIL cfg_sel3_ignored: got %0d expected 2", o); end
        cfg_write(2'd1, 7'd0, 16'h8000);
        cfg_write(2'd2, 7'd0, 16'h7fff);
        run_beat(-16'sd123, 1'b1, 0, 2'd0, 16'd0, o, s, lat);
        checks++; if (o !== -16'sd123) begin errors++; $display("FAIL bypass_value: got %0d expected -123", o); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL bypass_sat: got %b expected 0", s); end
        cfg_write(2'd1, 7'd0, 16'd30);
        cfg_write(2'd2, 7'd0, 16'd5);
    endtask

    task automatic test_reset_mid;
        logic signed [15:0] o; logic s; int lat;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int l = 0; l < LANES; l++) in_data[l*DW +: DW] = 16'd100;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_out_data: got %h expected 0", out_data); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        run_beat(16'sd7, 1'b0, 0, 2'd0, 16'd0, o, s, lat);
        checks++; if (o !== 16'sd7) begin errors++; $display("FAIL rstmid_d7: got %0d expected 7", o); end
        run_beat(-16'sd7, 1'b0, 0, 2'd0, 16'd0, o, s, lat);
        checks++; if (o !== 16'sd0) begin errors++; $display("FAIL rstmid_d-7: got %0d expected 0", o); end
    endtask

    task automatic test_group_sweep;
        int eg;
        int exp_g[8];
        do_reset;
        @(posedge clk); #1;
        for (int ch = 0; ch < 128; ch++) cfg_write(2'd2, 7'(ch), 16'(ch));
        stream(2*G, -1, 1'b0);
        checks++; if (q_data.size() != 2*G) begin errors++; $display("FAIL sweep_count: got %0d expected %0d", q_data.size(), 2*G); end
        for (int i = 0; i < q_data.size(); i++) begin
            checks++; if (q_grp[i] !== 4'(i % G)) begin errors++; $display("FAIL sweep_grp[%0d]: got %0d expected %0d", i, q_grp[i], i % G); end
            checks++; if (q_last[i] !== ((i % G) == G-1)) begin errors++; $display("FAIL sweep_last[%0d]: got %b expected %b", i, q_last[i], (i % G) == G-1); end
            checks++; if (q_data[i] !== exp_vec(i, i % G) || q_sat[i] !== 1'b0) begin errors++; $display("FAIL sweep_data[%0d]: got %h sat %b expected %h sat 0", i, q_data[i], q_sat[i], exp_vec(i, i % G)); end
        end
        eg = 0;
        for (int i = 0; i < 8; i++) begin
            exp_g[i] = eg;
            eg = (i == 4) ? 0 : (eg + 1) % G;
        end
        stream(8, 4, 1'b0);
        checks++; if (q_data.size() != 8) begin errors++; $display("FAIL clr_count: got %0d expected 8", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 8; i++) begin
            checks++; if (q_grp[i] !== 4'(exp_g[i]) || q_data[i] !== exp_vec(i, exp_g[i])) begin errors++; $display("FAIL clr_beat[%0d]: got grp %0d data %h expected grp %0d data %h", i, q_grp[i], q_data[i], exp_g[i], exp_vec(i, exp_g[i])); end
        end
    endtask

    task automatic test_backpressure;
        stream(64, -1, 1'b1);
        checks++; if (q_data.size() != 64) begin errors++; $display("FAIL bp_count: got %0d expected 64", q_data.size()); end
        for (int i = 0; i < q_data.size(); i++) begin
            checks++; if (q_grp[i] !== 4'(i % G) || q_data[i] !== exp_vec(i, i % G)) begin errors++; $display("FAIL bp_beat[%0d]: got grp %0d data %h expected grp %0d data %h", i, q_grp[i], q_data[i], i % G, exp_vec(i, i % G)); end
        end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d unstable cycles expected 0", stall_bad); end
        checks++; if (rdy_bad != 0) begin errors++; $display("FAIL bp_in_ready: got %0d wrong cycles expected 0", rdy_bad); end
    endtask

    initial begin
        test_reset;
        test_positive;
        test_negative;
        test_saturation;
        test_config_bypass;
        test_reset_mid;
        test_group_sweep;
        test_backpressure;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
